// File: rtl/acc_reduce.sv
// acc_reduce: accumulates i_len beats onto a bias and reduces mod q (2^15 or 2^16).
// Optional macro ACC_REDUCE_SUB_EN adds port i_sub to subtract beats instead of adding.
module acc_reduce #(
   parameter int WIDTH = 16,
   parameter int LEN_W = 11
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [2:0]       i_sec_lev,
   input  logic             i_start,
   input  logic [LEN_W-1:0] i_len,
   input  logic [WIDTH-1:0] i_init,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_element,
`ifdef ACC_REDUCE_SUB_EN
   input  logic             i_sub,
`endif
   output logic             o_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_result,
   input  logic             i_ready,
   output logic             o_busy
);
   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
   state_t state, nxt_state;
   logic [WIDTH-1:0] acc, sum, mask, start_mask;
   logic [LEN_W-1:0] cnt;
   logic sub, start, beat;
   assign start = state == IDLE && i_start;
   assign beat = state == ACC && i_valid;
   assign start_mask = i_sec_lev == 3'd1 ? {1'b0, {(WIDTH-1){1'b1}}} : '1;
   assign sum = sub ? acc - i_element : acc + i_element;
   assign o_ready = state == ACC;
   assign o_valid = state == OUT;
   assign o_busy = state != IDLE;
`ifndef ACC_REDUCE_SUB_EN
   assign sub = 1'b0;
`endif
   always_comb begin
      nxt_state = state;
      nxt_state = start ? (i_len != '0 ? ACC : OUT) :
                  (beat && cnt == LEN_W'(1)) ? OUT :
                  (state == OUT && i_ready) ? IDLE : state;
   end
   always_ff @(posedge i_clk)
      if (i_rst) state <= IDLE;
      else state <= nxt_state;
   // upper bits of acc are kept mid-job; masking at the output is exact for power-of-two q
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc <= '0;
         cnt <= '0;
         mask <= '0;
         o_result <= '0;
`ifdef ACC_REDUCE_SUB_EN
         sub <= 1'b0;
`endif
      end else begin
         if (start) begin
            acc <= i_init;
            cnt <= i_len;
            mask <= start_mask;
`ifdef ACC_REDUCE_SUB_EN
            sub <= i_sub;
`endif
            if (i_len == '0) o_result <= i_init & start_mask;
         end
         if (beat) begin
            acc <= sum;
            cnt <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) o_result <= sum & mask;
         end
      end
   end
endmodule

// File: tb/tb_acc_reduce.sv
// tb_acc_reduce: randomized jobs checked against an arithmetic mod-q reference model.
module tb_acc_reduce;
   logic        clk = 0, rst = 1;
   logic [2:0]  i_sec_lev = 0;
   logic        i_start = 0, i_valid = 0, i_ready = 0, i_sub = 0;
   logic [10:0] i_len = 0;
   logic [15:0] i_init = 0, i_element = 0;
   logic        o_ready, o_valid, o_busy;
   logic [15:0] o_result;
   int n_vec = 0, n_err = 0;
   int bq[$];

   acc_reduce dut (
      .i_clk(clk), .i_rst(rst), .i_sec_lev(i_sec_lev), .i_start(i_start), .i_len(i_len),
      .i_init(i_init), .i_valid(i_valid), .i_element(i_element),
`ifdef ACC_REDUCE_SUB_EN
      .i_sub(i_sub),
`endif
      .o_ready(o_ready), .o_valid(o_valid), .o_result(o_result), .i_ready(i_ready), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic int model(input int sec, input int init, input int beats[$], input bit sub);
      longint a = init;
      longint q = sec == 1 ? 32768 : 65536;
      foreach (beats[k]) a = sub ? a - beats[k] : a + beats[k];
      return int'(((a % q) + q) % q);
   endfunction

   // called at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE
   task automatic job(input int sec, input int init, input int beats[$], input bit sub,
                      input int vprob, input int stall);
      int exp, k, cyc, len;
      bit v;
      len = beats.size();
      exp = model(sec, init, beats, sub);
      chk("idle_busy", o_busy, 0);
      chk("idle_ready", o_ready, 0);
      i_start = 1; i_sec_lev = 3'(sec); i_len = 11'(len); i_init = 16'(init); i_sub = sub;
      i_valid = 1; i_element = 16'hdead; i_ready = 0;
      @(negedge clk);
      i_sec_lev = 3'($urandom); i_len = 11'($urandom); i_init = 16'($urandom); i_sub = 1'($urandom);
      k = 0; cyc = 0;
      while (k < len && cyc < 2000) begin
         chk("acc_ready", o_ready, 1);
         chk("acc_valid", o_valid, 0);
         v = $urandom_range(99) < vprob;
         i_valid = v;
         i_element = v ? 16'(beats[k]) : 16'($urandom);
         i_start = 1'($urandom);
         @(negedge clk);
         if (v) k++;
         cyc++;
      end
      if (cyc >= 2000) chk("acc_timeout", cyc, 0);
      for (int s = 0; s <= stall; s++) begin
         chk("out_valid", o_valid, 1);
         chk("out_result", o_result, exp);
         chk("out_ready", o_ready, 0);
         chk("out_busy", o_busy, 1);
         i_ready = s == stall;
         i_valid = 1; i_element = 16'($urandom);
         i_start = s != stall;
         @(negedge clk);
      end
      i_ready = 0; i_valid = 0; i_start = 0;
      chk("done_valid", o_valid, 0);
      chk("done_busy", o_busy, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 0;
      chk("rst_ready", o_ready, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_result", o_result, 0);
      chk("rst_busy", o_busy, 0);
      bq = {32'h1};
      job(1, 'h7fff, bq, 0, 100, 0);
      bq = {32'h1000, 32'h1000, 32'h1000, 32'h1000};
      job(3, 'h10, bq, 0, 100, 0);
      bq = {};
      job(1, 'hffff, bq, 0, 100, 0);
      bq = {32'h5, 32'h5, 32'h5};
      job(3, 0, bq, 0, 50, 5);
      i_start = 1; i_sec_lev = 3; i_len = 4; i_init = 9;
      @(negedge clk);
      i_start = 0; i_valid = 1; i_element = 7;
      repeat (2) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0; i_valid = 0;
      chk("midrst_ready", o_ready, 0);
      chk("midrst_valid", o_valid, 0);
      chk("midrst_result", o_result, 0);
      chk("midrst_busy", o_busy, 0);
      bq = {32'h3};
      job(3, 0, bq, 0, 100, 0);
`ifdef ACC_REDUCE_SUB_EN
      bq = {32'h1, 32'h2};
      job(1, 2, bq, 1, 100, 0);
`endif
      for (int j = 0; j < 40; j++) begin
         int len = $urandom_range(20);
         bit sub = 0;
         bq = {};
         for (int b = 0; b < len; b++) bq.push_back(int'($urandom_range(16'hffff)));
`ifdef ACC_REDUCE_SUB_EN
         sub = 1'($urandom);
`endif
         job($urandom_range(7), $urandom_range(16'hffff), bq, sub, $urandom_range(30, 100),
             $urandom_range(3));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
